// File: rtl/sawtooth_gen_pkg.sv
// Shared definitions for the sawtooth ramp generator: default widths and FSM encoding.
// Imported by the top and the prescaler so both agree on widths and state values.
package sawtooth_gen_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int DIV_W_DEF = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } saw_state_e;

endpackage

// File: rtl/sawtooth_gen_prescaler.sv
// Step-rate prescaler: free-running down-counter reloaded with div_i, ticking at zero.
// clr_i parks the counter at zero so the first enabled clock produces a tick.
module saw_prescaler
  import sawtooth_gen_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clc_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] ps_q;
  logic [DIV_W-1:0] ps_d;
  logic             at_zero;

  assign at_zero = (ps_q == '0);

  always_comb begin
    ps_d = ps_q;
    if (clr_i) begin
      ps_d = '0;
    end else if (at_zero) begin
      // div_i is only looked at here, so a change lands at the next reload
      ps_d = div_i;
    end else begin
      ps_d = ps_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clc_i or negedge rst_i) begin
    if (!rst_i) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end

  assign tick_o = !clr_i && at_zero;

endmodule

// File: rtl/sawtooth_gen.sv
// Sawtooth ramp generator: counts N1..N2 at the prescaled rate and wraps to N1.
// Limits are double-buffered and take effect only at a wrap or while idle.
module sawtooth_gen
  import sawtooth_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clc_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] N1_data_i,
  input  logic [CNT_W-1:0] N2_data_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
  output logic [CNT_W-1:0] sawtooth_cntr_o,
  output logic             wrap_o,
  output logic             lim_err_o,
  output logic             pend_o,
  output saw_state_e       state_o
);

  saw_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_n1_q, act_n1_d;
  logic [CNT_W-1:0] act_n2_q, act_n2_d;
  logic [CNT_W-1:0] pend_n1_q, pend_n1_d;
  logic [CNT_W-1:0] pend_n2_q, pend_n2_d;
  logic             pend_q, pend_d;
  logic             wrap_q, wrap_d;
  logic             lim_err_q, lim_err_d;

  logic             tick;
  logic             load_ok;
  logic             apply;
  logic [CNT_W-1:0] fwd_n1;
  logic [CNT_W-1:0] fwd_n2;
  logic             fwd_pend;
  logic [CNT_W-1:0] next_n1;

  saw_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clc_i  (clc_i),
    .rst_i  (rst_i),
    .clr_i  (state_q == ST_IDLE),
    .div_i  (div_i),
    .tick_o (tick)
  );

  // A load arriving this clock is forwarded so a coincident apply sees it
  assign load_ok  = load_i && (N2_data_i >= N1_data_i);
  assign fwd_n1   = load_ok ? N1_data_i : pend_n1_q;
  assign fwd_n2   = load_ok ? N2_data_i : pend_n2_q;
  assign fwd_pend = load_ok || pend_q;
  assign next_n1  = fwd_pend ? fwd_n1 : act_n1_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    act_n1_d  = act_n1_q;
    act_n2_d  = act_n2_q;
    pend_n1_d = pend_n1_q;
    pend_n2_d = pend_n2_q;
    pend_d    = pend_q;
    wrap_d    = 1'b0;
    lim_err_d = load_i && !load_ok;
    apply     = 1'b0;

    if (load_ok) begin
      pend_n1_d = N1_data_i;
      pend_n2_d = N2_data_i;
      pend_d    = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        apply = fwd_pend;
        cnt_d = next_n1;
        if (en_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!en_i) begin
          state_d = ST_IDLE;
          cnt_d   = act_n1_q;
        end else if (tick) begin
          if (cnt_q == act_n2_q) begin
            wrap_d = 1'b1;
            apply  = fwd_pend;
            cnt_d  = next_n1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (apply) begin
      act_n1_d = fwd_n1;
      act_n2_d = fwd_n2;
      pend_d   = 1'b0;
    end
  end

  always_ff @(posedge clc_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      act_n1_q  <= '0;
      act_n2_q  <= '1;
      pend_n1_q <= '0;
      pend_n2_q <= '0;
      pend_q    <= 1'b0;
      wrap_q    <= 1'b0;
      lim_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      act_n1_q  <= act_n1_d;
      act_n2_q  <= act_n2_d;
      pend_n1_q <= pend_n1_d;
      pend_n2_q <= pend_n2_d;
      pend_q    <= pend_d;
      wrap_q    <= wrap_d;
      lim_err_q <= lim_err_d;
    end
  end

  assign sawtooth_cntr_o = cnt_q;
  assign wrap_o          = wrap_q;
  assign lim_err_o       = lim_err_q;
  assign pend_o          = pend_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_sawtooth_gen.sv
// Directed bench for sawtooth_gen: per-clock vector table plus hand sequences
// for the full-range ramp and asynchronous reset mid-ramp.
module tb_sawtooth_gen;
  import sawtooth_gen_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [7:0]  n1;
  logic [7:0]  n2;
  logic        load;
  logic [15:0] div;
  logic [7:0]  cnt;
  logic        wrap;
  logic        lim_err;
  logic        pend;
  saw_state_e  state;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        en;
    logic        load;
    logic [7:0]  n1;
    logic [7:0]  n2;
    logic [15:0] div;
    logic [7:0]  exp_cnt;
    logic        exp_wrap;
    logic        exp_err;
    logic        exp_pend;
  } vec_t;

  vec_t vecs[$];

  sawtooth_gen #(
    .CNT_W (8),
    .DIV_W (16)
  ) dut (
    .clc_i           (clk),
    .rst_i           (rst_n),
    .en_i            (en),
    .N1_data_i       (n1),
    .N2_data_i       (n2),
    .load_i          (load),
    .div_i           (div),
    .sawtooth_cntr_o (cnt),
    .wrap_o          (wrap),
    .lim_err_o       (lim_err),
    .pend_o          (pend),
    .state_o         (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic e, logic l, logic [7:0] a, logic [7:0] b,
                              logic [15:0] d, logic [7:0] c, logic w,
                              logic er, logic p);
    vec_t v;
    v.en = e; v.load = l; v.n1 = a; v.n2 = b; v.div = d;
    v.exp_cnt = c; v.exp_wrap = w; v.exp_err = er; v.exp_pend = p;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic e, input logic l, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] d);
    en = e; load = l; n1 = a; n2 = b; div = d;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(1'b0, 1'b0, 8'd0, 8'd0, 16'd0);

    // en, load, n1, n2, div | cnt, wrap, err, pend
    // load 10/13 in idle, then run at div=0
    vecs.push_back(mk(0, 1, 10, 13, 0,  10, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  0,  10, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  0,  11, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  0,  12, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  0,  13, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  0,  10, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  0,  11, 0, 0, 0));
    // pending 50/52 loaded at cnt=11, applied at the wrap
    vecs.push_back(mk(1, 1, 50, 52, 0,  12, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0,  0,  0,  13, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0,  0,  0,  50, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  0,  51, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  0,  52, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  0,  50, 1, 0, 0));
    // rejected load 20/15
    vecs.push_back(mk(1, 1, 20, 15, 0,  51, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0,  0,  0,  52, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  0,  50, 1, 0, 0));
    // load 60/61 coincident with the wrap tick
    vecs.push_back(mk(1, 0, 0,  0,  0,  51, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  0,  52, 0, 0, 0));
    vecs.push_back(mk(1, 1, 60, 61, 0,  60, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  0,  61, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  0,  60, 1, 0, 0));
    // disable, reload 10/13, run to 12, disable mid-ramp
    vecs.push_back(mk(0, 0, 0,  0,  0,  60, 0, 0, 0));
    vecs.push_back(mk(0, 1, 10, 13, 0,  10, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  0,  10, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  0,  11, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  0,  12, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0,  0,  10, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0,  0,  10, 0, 0, 0));
    // n1 == n2 == 7: wrap every tick
    vecs.push_back(mk(0, 1, 7,  7,  0,  7,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  0,  7,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  0,  7,  1, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  0,  7,  1, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  0,  7,  1, 0, 0));
    // leave run with a load pending, apply in idle, run 0..2 at div=3
    vecs.push_back(mk(0, 1, 0,  2,  3,  7,  0, 0, 1));
    vecs.push_back(mk(0, 0, 0,  0,  3,  0,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  3,  0,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  3,  1,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  3,  1,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  3,  1,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  3,  1,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  3,  2,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  3,  2,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  3,  2,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  3,  2,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  3,  0,  1, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  3,  0,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  3,  0,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  3,  0,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,  3,  1,  0, 0, 0));

    // reset state
    repeat (3) @(negedge clk);
    check("rst_cnt", cnt, 0);
    check("rst_wrap", wrap, 0);
    check("rst_err", lim_err, 0);
    check("rst_pend", pend, 0);
    check("rst_state", state, ST_IDLE);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].load, vecs[i].n1, vecs[i].n2, vecs[i].div);
      step();
      check($sformatf("v%0d_cnt", i), cnt, vecs[i].exp_cnt);
      check($sformatf("v%0d_wrap", i), wrap, vecs[i].exp_wrap);
      check($sformatf("v%0d_err", i), lim_err, vecs[i].exp_err);
      check($sformatf("v%0d_pend", i), pend, vecs[i].exp_pend);
    end

    // full range 0..255 at div=0
    drive(1'b0, 1'b1, 8'd0, 8'd255, 16'd0);
    step();
    drive(1'b0, 1'b0, 8'd0, 8'd0, 16'd0);
    step();
    check("fr_idle_cnt", cnt, 0);
    en = 1'b1;
    step();
    check("fr_start_cnt", cnt, 0);
    for (int i = 1; i <= 256; i++) begin
      step();
      check($sformatf("fr%0d_cnt", i), cnt, (i == 256) ? 0 : i);
      check($sformatf("fr%0d_wrap", i), wrap, (i == 256) ? 1 : 0);
    end

    // pending load while running, then async reset mid-ramp
    step();
    step();
    check("pre_rst_cnt", cnt, 2);
    load = 1'b1; n1 = 8'd5; n2 = 8'd6;
    step();
    load = 1'b0;
    check("pre_rst_pend", pend, 1);
    check("pre_rst_cnt2", cnt, 3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_cnt", cnt, 0);
    check("async_rst_pend", pend, 0);
    check("async_rst_state", state, ST_IDLE);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_cnt", cnt, 0);
    check("post_rst_pend", pend, 0);
    // restored n2 = 255: ramp climbs past the lost pending limit of 6
    en = 1'b1;
    repeat (10) step();
    check("post_rst_ramp", cnt, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
